spu_writeback_pipe: RTL and testbench

Result-staging and retirement pipeline for the dual-issue SPU: captures even- and odd-pipe results at issue, ages them through fixed-depth shift stages, and drives the register file write ports (`rt_even`, `rt_addr_even`, `reg_write_even`, `rt_odd`, `rt_addr_odd`, `reg_write_odd`) in program order at the final stage. It also answers forwarding lookups for the six source operands of the instruction pair being read. It sits between the execute units and the register table and is the writer side of the register-table write interface.

---
 rtl/spu_pkg.sv | 38 +++
 rtl/spu_writeback_pipe_if.sv | 44 ++++
 rtl/wb_shift_pipe.sv | 59 +++++
 rtl/spu_writeback_pipe.sv | 77 +++++++
 tb/tb_spu_writeback_pipe.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
// Shared types for the SPU writeback/forwarding path.
//   reg_addr_t : 7-bit register number
//   quad_t     : 128-bit register value
//   wb_entry_t : one in-flight result held in a staging slot
//   SRC_*      : index of each source operand in the forwarding lookup arrays
package spu_pkg;

   typedef logic [0:6]   reg_addr_t;
   typedef logic [0:127] quad_t;
   typedef logic [2:0]   lat_t;
   typedef logic [3:0]   age_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t rt_addr;
      quad_t     value;
      lat_t      lat;
      age_t      age;
   } wb_entry_t;

   localparam int unsigned NUM_SRC       = 6;
   localparam int unsigned SRC_RC_EVEN   = 0;
   localparam int unsigned SRC_RA_EVEN   = 1;
   localparam int unsigned SRC_RB_EVEN   = 2;
   localparam int unsigned SRC_RT_ST_ODD = 3;
   localparam int unsigned SRC_RA_ODD    = 4;
   localparam int unsigned SRC_RB_ODD    = 5;

   // A latency of 0 is treated as single-cycle.
   function automatic lat_t norm_lat(input lat_t lat);
      return (lat == '0) ? lat_t'(1) : lat;
   endfunction

   function automatic logic entry_ready(input wb_entry_t e);
      return {1'b0, e.lat} <= e.age;
   endfunction

endpackage

// File: rtl/spu_writeback_pipe_if.sv
// Bundle between the execute/issue side (master) and the writeback pipe (slave).
//   issue  : ev_/od_ valid, rt_addr, result, lat; flush
//   lookup : src_addr[6] in, fwd_hit[6] / fwd_data[6] / fwd_stall out
//   retire : rt_even/odd, rt_addr_even/odd, reg_write_even/odd toward the register table
interface spu_writeback_pipe_if;
   import spu_pkg::*;

   logic      ev_valid;
   reg_addr_t ev_rt_addr;
   quad_t     ev_result;
   lat_t      ev_lat;
   logic      od_valid;
   reg_addr_t od_rt_addr;
   quad_t     od_result;
   lat_t      od_lat;
   logic      flush;

   reg_addr_t src_addr [NUM_SRC];
   logic      fwd_hit  [NUM_SRC];
   quad_t     fwd_data [NUM_SRC];
   logic      fwd_stall;

   quad_t     rt_even;
   quad_t     rt_odd;
   reg_addr_t rt_addr_even;
   reg_addr_t rt_addr_odd;
   logic      reg_write_even;
   logic      reg_write_odd;

   modport master (
      output ev_valid, ev_rt_addr, ev_result, ev_lat,
      output od_valid, od_rt_addr, od_result, od_lat, flush, src_addr,
      input  fwd_hit, fwd_data, fwd_stall,
      input  rt_even, rt_odd, rt_addr_even, rt_addr_odd, reg_write_even, reg_write_odd
   );

   modport slave (
      input  ev_valid, ev_rt_addr, ev_result, ev_lat,
      input  od_valid, od_rt_addr, od_result, od_lat, flush, src_addr,
      output fwd_hit, fwd_data, fwd_stall,
      output rt_even, rt_odd, rt_addr_even, rt_addr_odd, reg_write_even, reg_write_odd
   );

endinterface

// File: rtl/wb_shift_pipe.sv
// One result-staging pipe: DEPTH slots, slot 0 loaded at issue, every slot shifts
// one place per cycle while its age counts up (saturating at DEPTH).
//   clk, rst_n : clock, asynchronous active-low reset (clears all slots)
//   flush_i    : kill everything not retiring this cycle and drop the current issue
//   issue_i, addr_i, value_i, lat_i : result entering slot 0
//   stage_o    : full slot array, slot DEPTH-1 is the retiring one
module wb_shift_pipe import spu_pkg::*; #(
   parameter int unsigned DEPTH = 7
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush_i,
   input  logic      issue_i,
   input  reg_addr_t addr_i,
   input  quad_t     value_i,
   input  lat_t      lat_i,
   output wb_entry_t stage_o [DEPTH]
);

   localparam age_t AGE_MAX = age_t'(DEPTH);

   wb_entry_t stage_q [DEPTH];
   wb_entry_t stage_d [DEPTH];

   always_comb begin
      stage_d[0] = '0;
      if (issue_i && !flush_i) begin
         stage_d[0].valid   = 1'b1;
         stage_d[0].rt_addr = addr_i;
         stage_d[0].value   = value_i;
         stage_d[0].lat     = norm_lat(lat_i);
         stage_d[0].age     = age_t'(1);
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
         if (stage_q[i-1].age < AGE_MAX) begin
            stage_d[i].age = stage_q[i-1].age + age_t'(1);
         end
         // The entry leaving slot DEPTH-1 has already retired, so flushing
         // every shifted-in slot kills exactly the non-retiring entries.
         if (flush_i) begin
            stage_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign stage_o = stage_q;

endmodule

// File: rtl/spu_writeback_pipe.sv
// Dual-pipe result staging and retirement for the SPU, plus operand forwarding.
//   clk   : clock
//   reset : asynchronous active-low reset
//   wb    : slave side of spu_writeback_pipe_if (issue, lookup, register-table writes)
// Retirement outputs come straight from the last slot of each pipe; forwarding
// picks the youngest matching entry across both pipes, odd winning a tie.
module spu_writeback_pipe import spu_pkg::*; #(
   parameter int unsigned DEPTH = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   spu_writeback_pipe_if.slave   wb
);

   wb_entry_t ev_st [DEPTH];
   wb_entry_t od_st [DEPTH];

   wb_shift_pipe #(.DEPTH(DEPTH)) u_even (
      .clk     (clk),
      .rst_n   (reset),
      .flush_i (wb.flush),
      .issue_i (wb.ev_valid),
      .addr_i  (wb.ev_rt_addr),
      .value_i (wb.ev_result),
      .lat_i   (wb.ev_lat),
      .stage_o (ev_st)
   );

   wb_shift_pipe #(.DEPTH(DEPTH)) u_odd (
      .clk     (clk),
      .rst_n   (reset),
      .flush_i (wb.flush),
      .issue_i (wb.od_valid),
      .addr_i  (wb.od_rt_addr),
      .value_i (wb.od_result),
      .lat_i   (wb.od_lat),
      .stage_o (od_st)
   );

   // Retirement: payload is zeroed when the last slot is empty.
   assign wb.reg_write_even = ev_st[DEPTH-1].valid;
   assign wb.rt_addr_even   = ev_st[DEPTH-1].valid ? ev_st[DEPTH-1].rt_addr : '0;
   assign wb.rt_even        = ev_st[DEPTH-1].valid ? ev_st[DEPTH-1].value   : '0;
   assign wb.reg_write_odd  = od_st[DEPTH-1].valid;
   assign wb.rt_addr_odd    = od_st[DEPTH-1].valid ? od_st[DEPTH-1].rt_addr : '0;
   assign wb.rt_odd         = od_st[DEPTH-1].valid ? od_st[DEPTH-1].value   : '0;

   logic [NUM_SRC-1:0] stall_c;
   wb_entry_t          sel;
   int unsigned        idx;

   always_comb begin
      sel     = '0;
      idx     = 0;
      stall_c = '0;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
         sel = '0;
         // Walk oldest to youngest so the last match kept is the youngest;
         // odd is tested after even so it wins within the same slot.
         for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = DEPTH - 1 - k;
            if (ev_st[idx].valid && (ev_st[idx].rt_addr == wb.src_addr[s])) begin
               sel = ev_st[idx];
            end
            if (od_st[idx].valid && (od_st[idx].rt_addr == wb.src_addr[s])) begin
               sel = od_st[idx];
            end
         end
         wb.fwd_hit[s]  = sel.valid && entry_ready(sel);
         wb.fwd_data[s] = (sel.valid && entry_ready(sel)) ? sel.value : '0;
         stall_c[s]     = sel.valid && !entry_ready(sel);
      end
   end

   assign wb.fwd_stall = |stall_c;

endmodule

// File: tb/tb_spu_writeback_pipe.sv
module tb_spu_writeback_pipe;
   import spu_pkg::*;

   localparam int unsigned DEPTH   = 7;
   localparam reg_addr_t   NO_ADDR = 7'd127;

   typedef struct {
      reg_addr_t addr;
      quad_t     value;
      int        due;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   failures;
   exp_t ev_q[$];
   exp_t od_q[$];
   bit   mon_we_ev;
   bit   mon_we_od;
   int   c0;
   quad_t v;

   spu_writeback_pipe_if wb ();

   spu_writeback_pipe #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb.ev_valid = 1'b0;
      wb.od_valid = 1'b0;
      wb.flush    = 1'b0;
   endtask

   task automatic set_src(input reg_addr_t a);
      for (int i = 0; i < int'(NUM_SRC); i++) wb.src_addr[i] = a;
   endtask

   task automatic issue_ev(input reg_addr_t a, input quad_t val, input lat_t l);
      exp_t e;
      wb.ev_valid   = 1'b1;
      wb.ev_rt_addr = a;
      wb.ev_result  = val;
      wb.ev_lat     = l;
      e.addr = a; e.value = val; e.due = cyc + int'(DEPTH);
      ev_q.push_back(e);
   endtask

   task automatic issue_od(input reg_addr_t a, input quad_t val, input lat_t l);
      exp_t e;
      wb.od_valid   = 1'b1;
      wb.od_rt_addr = a;
      wb.od_result  = val;
      wb.od_lat     = l;
      e.addr = a; e.value = val; e.due = cyc + int'(DEPTH);
      od_q.push_back(e);
   endtask

   // Everything not retiring in the current cycle is killed, including this cycle's issues.
   task automatic do_flush();
      wb.flush = 1'b1;
      while (ev_q.size() > 0 && ev_q[$].due > cyc) void'(ev_q.pop_back());
      while (od_q.size() > 0 && od_q[$].due > cyc) void'(od_q.pop_back());
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         tick();
         idle();
      end
   endtask

   task automatic check_fwd(input string tag, input int s, input bit hit, input quad_t data, input bit stall);
      check_eq({tag, "_hit"},   128'(wb.fwd_hit[s]),  128'(hit));
      check_eq({tag, "_data"},  128'(wb.fwd_data[s]), 128'(data));
      check_eq({tag, "_stall"}, 128'(wb.fwd_stall),   128'(stall));
   endtask

   // Write-port scoreboard: an entry is expected exactly in its due cycle.
   always @(negedge clk) begin
      mon_we_ev = (ev_q.size() > 0) && (ev_q[0].due == cyc);
      mon_we_od = (od_q.size() > 0) && (od_q[0].due == cyc);
      check_eq("we_even", 128'(wb.reg_write_even), 128'(mon_we_ev));
      if (mon_we_ev) begin
         check_eq("addr_even", 128'(wb.rt_addr_even), 128'(ev_q[0].addr));
         check_eq("data_even", 128'(wb.rt_even), 128'(ev_q[0].value));
         void'(ev_q.pop_front());
      end
      check_eq("we_odd", 128'(wb.reg_write_odd), 128'(mon_we_od));
      if (mon_we_od) begin
         check_eq("addr_odd", 128'(wb.rt_addr_odd), 128'(od_q[0].addr));
         check_eq("data_odd", 128'(wb.rt_odd), 128'(od_q[0].value));
         void'(od_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      idle();
      wb.ev_rt_addr = '0; wb.ev_result = '0; wb.ev_lat = '0;
      wb.od_rt_addr = '0; wb.od_result = '0; wb.od_lat = '0;
      set_src(NO_ADDR);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rt_even", 128'(wb.rt_even), '0);
      check_eq("rst_rt_odd", 128'(wb.rt_odd), '0);
      check_eq("rst_addr_even", 128'(wb.rt_addr_even), '0);
      check_eq("rst_addr_odd", 128'(wb.rt_addr_odd), '0);
      check_eq("rst_stall", 128'(wb.fwd_stall), '0);
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         check_eq("rst_hit", 128'(wb.fwd_hit[i]), '0);
         check_eq("rst_data", 128'(wb.fwd_data[i]), '0);
      end
      tick();
      reset = 1'b1;

      // Single even issue, lat 2: write only in cycle DEPTH-1 after capture
      tick(); idle();
      issue_ev(7'd5, {16{8'hAA}}, 3'd2);
      drain(DEPTH + 2);

      // Forwarding readiness window for lat 4
      tick(); idle();
      v = {4{32'h1234_5678}};
      issue_ev(7'd9, v, 3'd4);
      wb.src_addr[SRC_RA_EVEN] = 7'd9;
      for (int k = 0; k < 8; k++) begin
         tick(); idle();
         @(negedge clk);
         check_fwd("fwd9", SRC_RA_EVEN, (k >= 3 && k <= 6), (k >= 3 && k <= 6) ? v : '0, (k <= 2));
      end
      set_src(NO_ADDR);
      drain(2);

      // Younger odd beats older even
      tick(); idle(); issue_ev(7'd3, 128'd2, 3'd1);
      tick(); idle(); issue_od(7'd3, 128'd1, 3'd1);
      tick(); idle(); wb.src_addr[SRC_RB_ODD] = 7'd3;
      @(negedge clk);
      check_fwd("prio_young", SRC_RB_ODD, 1'b1, 128'd1, 1'b0);
      drain(DEPTH + 1);

      // Same-cycle issue: odd wins, both enables in retire cycle
      tick(); idle(); issue_ev(7'd3, 128'd2, 3'd1); issue_od(7'd3, 128'd1, 3'd1);
      tick(); idle();
      @(negedge clk);
      check_fwd("prio_same", SRC_RB_ODD, 1'b1, 128'd1, 1'b0);
      drain(DEPTH + 1);

      // Youngest match not ready: stall even though an older ready match exists
      tick(); idle(); issue_ev(7'd3, 128'd2, 3'd1);
      tick(); idle(); issue_od(7'd3, 128'd1, 3'd3);
      tick(); idle();
      @(negedge clk);
      check_fwd("stall_a0", SRC_RB_ODD, 1'b0, '0, 1'b1);
      tick(); idle();
      @(negedge clk);
      check_fwd("stall_a1", SRC_RB_ODD, 1'b0, '0, 1'b1);
      tick(); idle();
      @(negedge clk);
      check_fwd("stall_a2", SRC_RB_ODD, 1'b1, 128'd1, 1'b0);
      set_src(NO_ADDR);
      drain(DEPTH + 1);

      // Flush while the oldest of four is retiring
      tick(); idle();
      c0 = cyc;
      issue_ev(7'd40, 128'd40, 3'd2);
      for (int i = 1; i < 4; i++) begin
         tick(); idle();
         issue_ev(reg_addr_t'(40 + i), 128'(40 + i), 3'd2);
      end
      while (cyc < c0 + int'(DEPTH)) begin
         tick(); idle();
      end
      issue_ev(7'd50, 128'd50, 3'd1);
      do_flush();
      tick(); idle();
      wb.src_addr[SRC_RC_EVEN] = 7'd41;
      wb.src_addr[SRC_RA_ODD]  = 7'd50;
      @(negedge clk);
      check_fwd("flush41", SRC_RC_EVEN, 1'b0, '0, 1'b0);
      check_fwd("flush50", SRC_RA_ODD, 1'b0, '0, 1'b0);
      set_src(NO_ADDR);
      drain(DEPTH + 2);

      // Back-to-back random issues on both pipes
      for (int n = 0; n < 20; n++) begin
         tick(); idle();
         issue_ev(reg_addr_t'($urandom_range(0, 126)),
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  lat_t'($urandom_range(0, DEPTH - 1)));
         issue_od(reg_addr_t'($urandom_range(0, 126)),
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  lat_t'($urandom_range(0, DEPTH - 1)));
      end
      drain(DEPTH + 2);

      // Reset mid-operation: outputs clear immediately, pending writes are lost
      tick(); idle();
      c0 = cyc;
      wb.src_addr[SRC_RA_ODD] = 7'd20;
      issue_ev(7'd20, 128'h20, 3'd1);
      for (int i = 1; i < int'(DEPTH); i++) begin
         tick(); idle();
         issue_ev(reg_addr_t'(20 + i), 128'(32 + i), 3'd1);
      end
      tick(); idle();
      @(negedge clk);
      check_fwd("pre_rst", SRC_RA_ODD, 1'b1, 128'h20, 1'b0);
      #1;
      reset = 1'b0;
      ev_q.delete();
      od_q.delete();
      #1;
      check_eq("mid_rst_we_even", 128'(wb.reg_write_even), '0);
      check_eq("mid_rst_rt_even", 128'(wb.rt_even), '0);
      check_eq("mid_rst_addr_even", 128'(wb.rt_addr_even), '0);
      check_fwd("mid_rst", SRC_RA_ODD, 1'b0, '0, 1'b0);
      drain(2);
      reset = 1'b1;
      drain(DEPTH + 2);

      check_eq("sb_even_empty", 128'(ev_q.size()), '0);
      check_eq("sb_odd_empty", 128'(od_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
